wb_conmax_slave_arb: RTL

//  Per-slave-port arbiter for the conmax interconnect. Shares one slave port among NM

---
 rtl/wb_conmax_slave_arb.sv | 77 +++++++
 1 files changed

// File: rtl/wb_conmax_slave_arb.sv
// wb_conmax_slave_arb: per-slave-port priority/round-robin arbiter that shares one slave among NM masters
module wb_conmax_slave_arb #(
    parameter int NM = 8,
    parameter int PW = 2
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic [NM-1:0] i_req,
    input  logic [15:0]   i_conf,
    output logic [2:0]    o_gnt,
    output logic [NM-1:0] o_gnt_oh,
    output logic          o_gnt_vld,
    output logic          o_rearb
);
    localparam int NL = 1 << PW;
    typedef enum logic {IDLE, GRANT} state_t;
    state_t          r_state;
    logic [2:0]      r_gnt;
    logic [NM-1:0]   r_gnt_oh;
    logic            r_vld;
    logic            r_rearb;
    logic [2:0]      r_ptr [NL];
    logic [PW-1:0]   w_lvl [NM];
    logic [NM-1:0]   w_req_m;
    logic [PW-1:0]   w_max;
    logic [2:0]      w_win;
    logic            w_decide;
    // the releasing master is excluded from the handover decision; arbitrate on idle or release
    assign w_req_m  = (r_state == GRANT) ? (i_req & ~(NM'(1) << r_gnt)) : i_req;
    assign w_decide = (r_state == IDLE) || !i_req[r_gnt];
    // per-master priority level slices and highest level among the candidates
    always_comb begin
        w_max = '0;
        for (int i = 0; i < NM; i++) begin
            w_lvl[i] = i_conf[PW*i +: PW];
            if (w_req_m[i] && w_lvl[i] > w_max) w_max = w_lvl[i];
        end
    end
    // round-robin within the top level: scan down so the nearest index after ptr is assigned last
    always_comb begin
        w_win = r_ptr[w_max];
        for (int k = NM; k >= 1; k--)
            if (w_req_m[r_ptr[w_max] + 3'(k)] && w_lvl[r_ptr[w_max] + 3'(k)] == w_max)
                w_win = r_ptr[w_max] + 3'(k);
    end
    // grant FSM: hold while the owner requests, hand over directly or fall back to idle
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state  <= IDLE;
            r_gnt    <= '0;
            r_gnt_oh <= '0;
            r_vld    <= 1'b0;
            r_rearb  <= 1'b0;
            for (int l = 0; l < NL; l++) r_ptr[l] <= 3'(NM - 1);
        end else begin
            r_rearb <= 1'b0;
            if (w_decide) begin
                if (|w_req_m) begin
                    r_state      <= GRANT;
                    r_gnt        <= w_win;
                    r_gnt_oh     <= NM'(1) << w_win;
                    r_vld        <= 1'b1;
                    r_rearb      <= 1'b1;
                    r_ptr[w_max] <= w_win;
                end else begin
                    r_state  <= IDLE;
                    r_gnt_oh <= '0;
                    r_vld    <= 1'b0;
                end
            end
        end
    end
    assign o_gnt     = r_gnt;
    assign o_gnt_oh  = r_gnt_oh;
    assign o_gnt_vld = r_vld;
    assign o_rearb   = r_rearb;
endmodule
